// File: rtl/seqdet_pkg.sv
// Shared types and constants for the programmable sequence detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seqdet_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HUNT = 2'd1,
    HIT  = 2'd2
  } state_t;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

endpackage

// File: rtl/seqdet_hist_reg.sv
// Serial bit history with a saturating fill count; exposes the would-be shifted word.
// Latency: shift/flush take effect on the next rising edge; shifted/full_after_shift are combinational.
// Backpressure: none; the caller decides when to shift or flush (flush wins).
module seqdet_hist_reg #(
  parameter int PAT_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               shift,
  input  logic               flush,
  output logic [PAT_LEN-1:0] shifted,
  output logic               full_after_shift
);

  localparam int FW = $clog2(PAT_LEN + 1);

  // The oldest history bit falls off on every shift and is never compared,
  // so only the newest PAT_LEN-1 bits are kept.
  logic [PAT_LEN-2:0] hist;
  logic [FW-1:0]      fill;

  assign shifted          = {hist, din};
  assign full_after_shift = (fill >= FW'(PAT_LEN - 1));

  // History shift register and fill counter saturating at PAT_LEN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (flush) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= shifted[PAT_LEN-2:0];
      if (fill != FW'(PAT_LEN)) begin
        fill <= fill + FW'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable Moore serial sequence detector (overlap selectable); optional SEQDET_MATCH_CNT_EN adds Match_count.
// Latency: Y rises on the edge that accepts the final pattern bit; registered, no input-to-Y path.
// Backpressure: none; Din taken only when Din_valid is high, Pat_load > Clear > Din_valid.
module seq_detector_prog
  import seqdet_pkg::*;
#(
  parameter int                 PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0] DEFAULT_PAT = PAT_LEN'(DEFAULT_PATTERN),
  parameter int                 CNT_W       = 8
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Din,
  input  logic               Din_valid,
  input  logic               Overlap,
  input  logic               Pat_load,
  input  logic [PAT_LEN-1:0] Pat_in,
  input  logic               Clear,
  output logic               Y
`ifdef SEQDET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]   Match_count
`endif
);

  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX || CNT_W < 1) begin : g_bad_param
    $error("seq_detector_prog: PAT_LEN or CNT_W out of range");
  end

  state_t             state;
  state_t             state_nxt;
  logic [PAT_LEN-1:0] pattern;
  logic [PAT_LEN-1:0] shifted;
  logic               full_after_shift;
  logic               shift;
  logic               flush;
  logic               hit;

  seqdet_hist_reg #(
    .PAT_LEN (PAT_LEN)
  ) u_hist (
    .clk              (Clock),
    .rst_n            (Reset_n),
    .din              (Din),
    .shift            (shift),
    .flush            (flush),
    .shifted          (shifted),
    .full_after_shift (full_after_shift)
  );

  // Programmable pattern register; only Pat_load or reset changes it.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pattern <= DEFAULT_PAT;
    end else if (Pat_load) begin
      pattern <= Pat_in;
    end
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and history control; a match needs a full history so a
  // zeroed history after reset/flush can never fake an all-zero pattern.
  always_comb begin
    state_nxt = state;
    shift     = 1'b0;
    flush     = 1'b0;
    hit       = 1'b0;
    if (Pat_load || Clear) begin
      flush     = 1'b1;
      state_nxt = FILL;
    end else if (Din_valid) begin
      if (full_after_shift && (shifted == pattern)) begin
        hit       = 1'b1;
        state_nxt = HIT;
        if (Overlap) begin
          shift = 1'b1;
        end else begin
          flush = 1'b1;
        end
      end else begin
        shift     = 1'b1;
        state_nxt = full_after_shift ? HUNT : FILL;
      end
    end
  end

  assign Y = (state == HIT);

`ifdef SEQDET_MATCH_CNT_EN
  // Saturating match counter, zeroed whenever the history is restarted by the user.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Match_count <= '0;
    end else if (Pat_load || Clear) begin
      Match_count <= '0;
    end else if (hit && (Match_count != {CNT_W{1'b1}})) begin
      Match_count <= Match_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: directed vector table, corner sequences, randomized run vs queue model.
// Latency: checks Y one step after each driven cycle.
// Backpressure: n/a.
module tb_seq_detector_prog;

  localparam int L     = 4;
  localparam int CNT_W = 2;

  logic         Clock;
  logic         Reset_n;
  logic         Din;
  logic         Din_valid;
  logic         Overlap;
  logic         Pat_load;
  logic [L-1:0] Pat_in;
  logic         Clear;
  logic         Y;
`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] Match_count;
`endif

  seq_detector_prog #(
    .PAT_LEN (L),
    .CNT_W   (CNT_W)
  ) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .Din         (Din),
    .Din_valid   (Din_valid),
    .Overlap     (Overlap),
    .Pat_load    (Pat_load),
    .Pat_in      (Pat_in),
    .Clear       (Clear),
    .Y           (Y)
`ifdef SEQDET_MATCH_CNT_EN
    ,
    .Match_count (Match_count)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int nerr = 0;
  int nchk = 0;

  // Reference model: the accepted bit stream kept as a queue of recent bits.
  bit         mq[$];
  bit [L-1:0] m_pat;
  bit         m_y;
  int         m_cnt;

  typedef struct {
    logic         din;
    logic         vld;
    logic         ovl;
    logic         load;
    logic [L-1:0] pin;
    logic         clr;
    logic         exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pat = 4'b1101;
    m_y   = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_step(input bit din, input bit vld, input bit ovl,
                            input bit load, input bit [L-1:0] pin, input bit clr);
    bit [L-1:0] v;
    if (load) begin
      m_pat = pin;
      mq.delete();
      m_y   = 1'b0;
      m_cnt = 0;
    end else if (clr) begin
      mq.delete();
      m_y   = 1'b0;
      m_cnt = 0;
    end else if (vld) begin
      mq.push_back(din);
      if (mq.size() > L) void'(mq.pop_front());
      v = '0;
      foreach (mq[i]) v = {v[L-2:0], mq[i]};
      if (mq.size() == L && v == m_pat) begin
        m_y = 1'b1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!ovl) mq.delete();
      end else begin
        m_y = 1'b0;
      end
    end
  endtask

  // Drive one cycle, let the edge happen, then compare against the model.
  task automatic cyc(input logic din, input logic vld, input logic ovl,
                     input logic load, input logic [L-1:0] pin, input logic clr);
    Din = din; Din_valid = vld; Overlap = ovl;
    Pat_load = load; Pat_in = pin; Clear = clr;
    @(posedge Clock);
    #1;
    model_step(din, vld, ovl, load, pin, clr);
    chk("y_model", int'(Y), int'(m_y));
`ifdef SEQDET_MATCH_CNT_EN
    chk("count_model", int'(Match_count), m_cnt);
`endif
  endtask

  task automatic add(input logic din, input logic vld, input logic ovl,
                     input logic load, input logic [L-1:0] pin, input logic clr,
                     input logic exp);
    vec_t v;
    v.din = din; v.vld = vld; v.ovl = ovl; v.load = load;
    v.pin = pin; v.clr = clr; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic add_bits(input logic ovl, input string bits, input string exps);
    for (int i = 0; i < bits.len(); i++) begin
      add(bits[i] == "1", 1'b1, ovl, 1'b0, '0, 1'b0, exps[i] == "1");
    end
  endtask

  initial begin
    logic ovl_r;
    logic [L-1:0] pin_r;
    int   r;

    // Overlapping 1101 stream: hits after bits 4 and 7.
    add_bits(1'b1, "1101101", "0001001");
    add(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    // Non-overlapping: only the first hit.
    add_bits(1'b0, "1101101", "0001000");
    add(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    // Valid gaps: Y rises on final accepted 1, holds through idle, drops on next bit.
    add_bits(1'b1, "110", "000");
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    add_bits(1'b1, "1", "1");
    for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    add_bits(1'b1, "0", "0");
    add(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    // All-zero pattern: no hit until 4 zeros, then overlapping hits.
    add(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    add_bits(1'b1, "00000", "00011");
    // Reload 1101 while Y is high, then Clear discards its Din and restarts fill.
    add(1'b0, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0, 1'b0);
    add_bits(1'b1, "110", "000");
    add(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    add_bits(1'b1, "1101", "0001");
    // Pat_load together with Clear acts as a load; overlapping reuse of 1001.
    add(1'b1, 1'b1, 1'b1, 1'b1, 4'b1001, 1'b1, 1'b0);
    add_bits(1'b1, "1001001", "0001001");

    Reset_n = 1'b0; Din = 1'b0; Din_valid = 1'b0; Overlap = 1'b1;
    Pat_load = 1'b0; Pat_in = '0; Clear = 1'b0;
    model_reset();
    repeat (2) @(posedge Clock);
    #3;
    chk("reset_y", int'(Y), 0);
`ifdef SEQDET_MATCH_CNT_EN
    chk("reset_count", int'(Match_count), 0);
`endif
    @(negedge Clock);
    Reset_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].din, tbl[i].vld, tbl[i].ovl, tbl[i].load, tbl[i].pin, tbl[i].clr);
      chk($sformatf("vec%0d_y", i), int'(Y), int'(tbl[i].exp));
    end

    // Five overlapping zero-pattern hits saturate a 2-bit counter at 3.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("sat_y", int'(Y), 1);
`ifdef SEQDET_MATCH_CNT_EN
    chk("sat_count", int'(Match_count), 3);
`endif

    // Asynchronous reset mid-stream while Y is high.
    #2 Reset_n = 1'b0;
    #1;
    chk("async_reset_y", int'(Y), 0);
`ifdef SEQDET_MATCH_CNT_EN
    chk("async_reset_count", int'(Match_count), 0);
`endif
    model_reset();
    @(negedge Clock);
    Reset_n = 1'b1;
    // Pattern must be back to 1101.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("post_reset_default_pat", int'(Y), 1);

    // Randomized run against the model.
    ovl_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 19) == 0) ovl_r = ~ovl_r;
      case ($urandom_range(0, 3))
        0:       pin_r = 4'b1101;
        1:       pin_r = 4'b0000;
        2:       pin_r = 4'b1010;
        default: pin_r = L'($urandom);
      endcase
      cyc(1'($urandom), $urandom_range(0, 3) != 0, ovl_r,
          r < 2, pin_r, r >= 2 && r < 4);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
